// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit (1), DATA_W data bits, optional even parity, stop bit (0).
// Optional parity stage enabled by defining SERIAL_FRAME_RECEIVER_PARITY_EN.
module serial_frame_receiver #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              cc,
  input  logic              rr,
  input  logic              ssin,
  output logic [DATA_W-1:0] po,
  output logic              vld,
  output logic              ferr,
  output logic              perr,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam logic [1:0] PAR  = 2'd2;
`endif
  localparam logic [1:0] STOP = 2'd3;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              par_bad;

  // Shift direction decides which end of the word the first data bit lands in.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign shift_next = {ssin, shift_reg[DATA_W-1:1]};
    end else begin : g_msb_first
      assign shift_next = {shift_reg[DATA_W-2:0], ssin};
    end
  endgenerate

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  logic par_reg;
  logic perr_reg;

  // Even parity: data ones plus the parity bit must total an even count.
  assign par_bad = par_reg ^ (^shift_reg);
  assign perr    = perr_reg;

  always_ff @(posedge cc or negedge rr) begin
    if (!rr) begin
      par_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      perr_reg <= 1'b0;
      if (state_reg == PAR)
        par_reg <= ssin;
      if (state_reg == STOP)
        perr_reg <= par_bad;
    end
  end
`else
  assign par_bad = 1'b0;
  assign perr    = 1'b0;
`endif

  assign busy = (state_reg != IDLE);

  always_ff @(posedge cc or negedge rr) begin
    if (!rr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      po        <= '0;
      vld       <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      vld  <= 1'b0;
      ferr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ssin) begin
            state_reg <= DATA;
            cnt_reg   <= '0;
          end
        end
        DATA: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            state_reg <= PAR;
`else
            state_reg <= STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        PAR: begin
          state_reg <= STOP;
        end
`endif
        STOP: begin
          state_reg <= IDLE;
          ferr      <= ssin;
          if (!ssin && !par_bad) begin
            po  <= shift_reg;
            vld <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: one LSB-first and one MSB-first instance share the line.
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = DATA_W + 2;
  localparam bit PAR_EN     = 1'b0;
`endif

  logic              cc = 1'b0;
  logic              rr = 1'b0;
  logic              ssin = 1'b0;
  logic [DATA_W-1:0] po_l, po_m;
  logic              vld_l, ferr_l, perr_l, busy_l;
  logic              vld_m, ferr_m, perr_m, busy_m;

  serial_frame_receiver #(.DATA_W(DATA_W), .LSB_FIRST(1)) dut_lsb (
    .cc(cc), .rr(rr), .ssin(ssin), .po(po_l), .vld(vld_l),
    .ferr(ferr_l), .perr(perr_l), .busy(busy_l)
  );

  serial_frame_receiver #(.DATA_W(DATA_W), .LSB_FIRST(0)) dut_msb (
    .cc(cc), .rr(rr), .ssin(ssin), .po(po_m), .vld(vld_m),
    .ferr(ferr_m), .perr(perr_m), .busy(busy_m)
  );

  always #5 cc = ~cc;

  int cyc = 0;
  always @(posedge cc) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] po_l;
    logic [7:0] po_m;
    int         at_cyc;
  } exp_t;

  exp_t q_l[$];
  exp_t q_m[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] good_l = 8'h00;
  logic [7:0] good_m = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // w is the word as seen LSB-first; wm is the hand-computed MSB-first reading of the same bits.
  task automatic send_frame(input logic [7:0] w, input logic [7:0] wm,
                            input logic pbit, input logic stop);
    exp_t e;
    logic par_ok;
    check("busy_before_start", {31'd0, busy_l}, 32'd0);
    par_ok   = !PAR_EN || (pbit == ^w);
    e.v      = !stop && par_ok;
    e.f      = stop;
    e.p      = PAR_EN && !par_ok;
    if (e.v) begin
      good_l = w;
      good_m = wm;
    end
    e.po_l   = good_l;
    e.po_m   = good_m;
    e.at_cyc = cyc + FRAME_BITS;
    q_l.push_back(e);
    q_m.push_back(e);
    ssin = 1'b1;
    @(negedge cc);
    for (int i = 0; i < DATA_W; i++) begin
      check("busy_in_frame", {31'd0, busy_l}, 32'd1);
      ssin = w[i];
      @(negedge cc);
    end
    if (PAR_EN) begin
      ssin = pbit;
      @(negedge cc);
    end
    ssin = stop;
    @(negedge cc);
    ssin = 1'b0;
  endtask

  task automatic idle(input int n);
    ssin = 1'b0;
    repeat (n) @(negedge cc);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_po_lsb"}, {24'd0, po_l}, 32'd0);
    check({tag, "_po_msb"}, {24'd0, po_m}, 32'd0);
    check({tag, "_flags"}, {28'd0, vld_l, ferr_l, perr_l, busy_l}, 32'd0);
    check({tag, "_flags_msb"}, {28'd0, vld_m, ferr_m, perr_m, busy_m}, 32'd0);
  endtask

  always @(negedge cc) begin
    exp_t e;
    if (rr && (vld_l || ferr_l || perr_l)) begin
      if (q_l.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event_lsb: got vld=%0b ferr=%0b perr=%0b, expected none", vld_l, ferr_l, perr_l);
      end else begin
        e = q_l.pop_front();
        check("vld_lsb", {31'd0, vld_l}, {31'd0, e.v});
        check("ferr_lsb", {31'd0, ferr_l}, {31'd0, e.f});
        check("perr_lsb", {31'd0, perr_l}, {31'd0, e.p});
        check("po_lsb", {24'd0, po_l}, {24'd0, e.po_l});
        check("latency_lsb", cyc, e.at_cyc);
        check("busy_at_result_lsb", {31'd0, busy_l}, 32'd0);
        $display("lsb frame: cycle %0d vld=%0b ferr=%0b perr=%0b po=%02h", cyc, vld_l, ferr_l, perr_l, po_l);
      end
    end
  end

  always @(negedge cc) begin
    exp_t e;
    if (rr && (vld_m || ferr_m || perr_m)) begin
      if (q_m.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event_msb: got vld=%0b ferr=%0b perr=%0b, expected none", vld_m, ferr_m, perr_m);
      end else begin
        e = q_m.pop_front();
        check("vld_msb", {31'd0, vld_m}, {31'd0, e.v});
        check("ferr_msb", {31'd0, ferr_m}, {31'd0, e.f});
        check("perr_msb", {31'd0, perr_m}, {31'd0, e.p});
        check("po_msb", {24'd0, po_m}, {24'd0, e.po_m});
        check("latency_msb", cyc, e.at_cyc);
        $display("msb frame: cycle %0d vld=%0b ferr=%0b perr=%0b po=%02h", cyc, vld_m, ferr_m, perr_m, po_m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rr = 1'b0;
    ssin = 1'b0;
    repeat (2) @(negedge cc);
    check_reset_state("reset");
    rr = 1'b1;
    idle(2);

    // Framing error straight after reset: po must stay 0.
    send_frame(8'hA5, 8'hA5, 1'b0, 1'b1);
    idle(2);
    send_frame(8'hA5, 8'hA5, 1'b0, 1'b0);
    idle(3);

    // Abort a frame after four data bits with an asynchronous reset.
    ssin = 1'b1;
    @(negedge cc);
    for (int i = 0; i < 4; i++) begin
      ssin = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge cc);
    end
    rr = 1'b0;
    #1;
    check_reset_state("midframe_reset");
    good_l = 8'h00;
    good_m = 8'h00;
    ssin = 1'b0;
    @(negedge cc);
    rr = 1'b1;
    idle(2);
    send_frame(8'hA5, 8'hA5, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames with no idle gap.
    send_frame(8'h3C, 8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 8'hC3, 1'b0, 1'b0);
    idle(2);

    send_frame(8'h1E, 8'h78, 1'b0, 1'b0);
    send_frame(8'h96, 8'h69, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h01, 8'h80, 1'b1, 1'b0);
    idle(1);

    // Parity cases; without the parity stage only the good one is sent.
    send_frame(8'h07, 8'hE0, 1'b1, 1'b0);
    idle(1);
    if (PAR_EN) begin
      send_frame(8'h07, 8'hE0, 1'b0, 1'b0);
      idle(1);
      send_frame(8'h07, 8'hE0, 1'b0, 1'b1);
      idle(1);
    end

    // Line stuck at 1: consecutive all-ones frames each end in a framing error.
    send_frame(8'hFF, 8'hFF, 1'b1, 1'b1);
    send_frame(8'hFF, 8'hFF, 1'b1, 1'b1);
    send_frame(8'h00, 8'h00, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      if (q_l.size() == 0 && q_m.size() == 0) break;
      @(negedge cc);
    end
    check("pending_lsb", q_l.size(), 32'd0);
    check("pending_msb", q_m.size(), 32'd0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
